// File: rtl/launcher_pkg.sv
// Shared types and default sizing for the program launcher.
package launcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_RST,
    S_GAP,
    S_START,
    S_RUN,
    S_DUMP,
    S_DRAIN,
    S_FINISHED
  } launch_state_t;

  localparam int DEF_CYC_W      = 16;
  localparam int DEF_MAX_CYCLES = 1000;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_DUMP_WORDS = 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 8;

endpackage

// File: rtl/dump_reader.sv
// Data-memory read-back sequencer: walks addresses 0..DUMP_WORDS-1 once per
// start pulse and produces a valid/address strobe aligned with read data.
module dump_reader
  import launcher_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DUMP_WORDS = DEF_DUMP_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              last,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);

  logic              active;
  logic [ADDR_W-1:0] addr;

  assign last     = active && (addr == LAST_ADDR);
  assign mem_re   = active;
  assign mem_addr = active ? addr : '0;

  // Address walker: armed by start, stops after issuing the last address.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registers are updated with <= so every flop samples the values
    // from before the edge, independent of statement order.
    if (!reset) begin
      active <= 1'b0;
      addr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      addr   <= '0;
    end else if (active) begin
      if (addr == LAST_ADDR) active <= 1'b0;
      else                   addr   <= addr + 1'b1;
    end
  end

  // Strobe pipeline: the word appears one cycle after its read is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_valid <= 1'b0;
      dump_addr  <= '0;
    end else begin
      dump_valid <= mem_re;
      if (mem_re) dump_addr <= mem_addr;
    end
  end

endmodule

// File: rtl/program_launcher.sv
// Run controller for the 9-bit processor: resets it, pulses start, times the
// run until done or timeout, then streams back the first data-memory words.
module program_launcher
  import launcher_pkg::*;
#(
  parameter int CYC_W      = DEF_CYC_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int DUMP_WORDS = DEF_DUMP_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              cpu_reset,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam int                RST_W    = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  launch_state_t    state, state_next;
  logic [RST_W-1:0] rst_cnt;
  logic             launch;
  logic             run_exit;
  logic             dump_last;

  dump_reader #(
    .ADDR_W     (ADDR_W),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump_reader (
    .clk        (clk),
    .reset      (reset),
    .start      (run_exit),
    .last       (dump_last),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr)
  );

  // Read data arrives in the same cycle as its strobe; zero it otherwise.
  assign dump_data = dump_valid ? mem_rdata : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; go and cpu_done are only looked at where they matter.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    launch     = 1'b0;
    run_exit   = 1'b0;
    case (state)
      S_IDLE, S_FINISHED: begin
        if (go) begin
          state_next = S_HOLD_RST;
          launch     = 1'b1;
        end
      end
      S_HOLD_RST: if (rst_cnt == RST_LAST) state_next = S_GAP;
      S_GAP:      state_next = S_START;
      S_START:    state_next = S_RUN;
      S_RUN: begin
        if (cpu_done || (cycle_count == CYC_LAST)) begin
          run_exit   = 1'b1;
          state_next = S_DUMP;
        end
      end
      S_DUMP:     if (dump_last) state_next = S_DRAIN;
      S_DRAIN:    state_next = S_FINISHED;
      default:    state_next = S_IDLE;
    endcase
  end

  // Registered outputs and run bookkeeping. CPU reset/start follow the state
  // one cycle late, which puts start RST_CYCLES+2 cycles after go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_reset   <= 1'b1;
      cpu_start   <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
      rst_cnt     <= '0;
    end else begin
      cpu_reset <= (state == S_IDLE) || (state == S_HOLD_RST);
      cpu_start <= (state == S_START);
      busy      <= !((state_next == S_IDLE) || (state_next == S_FINISHED));
      finished  <= (state_next == S_FINISHED);
      rst_cnt   <= (state == S_HOLD_RST) ? rst_cnt + 1'b1 : '0;

      if (launch || (state == S_START))   cycle_count <= '0;
      else if ((state == S_RUN) && !run_exit) cycle_count <= cycle_count + 1'b1;

      if (launch)        timed_out <= 1'b0;
      else if (run_exit) timed_out <= !cpu_done;
    end
  end

endmodule
